decode_writeback: RTL and testbench

//   SEQ Y86-64 Decode + Write-Back stage. It sits between Fetch and Execute.

---
 rtl/y86_pkg.sv | 22 ++
 rtl/y86_regfile.sv | 41 ++++
 rtl/decode_writeback.sv | 87 ++++++++
 tb/tb_decode_writeback.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes and special register IDs.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP    = 4'h4;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam int         NREGS   = 15;

endpackage

// File: rtl/y86_regfile.sv
// 15x64 register file: two async read ports plus debug port; E and M write ports, M wins on collision.
// Reads are 0-cycle with no bypass; writes land on the edge; no backpressure, a write is taken every enabled edge.
module y86_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_en,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    output logic [63:0] dbg_val
);

    logic [63:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == int'(RRSP)) ? STACK_INIT : 64'd0;
            end
        end else if (wb_en) begin
            if (dst_e != RNONE) r_regs[dst_e] <= val_e;
            // Issued last so popq %rsp keeps the loaded value, not the incremented pointer.
            if (dst_m != RNONE) r_regs[dst_m] <= val_m;
        end
    end

    assign val_a   = (src_a   == RNONE) ? 64'd0 : r_regs[src_a];
    assign val_b   = (src_b   == RNONE) ? 64'd0 : r_regs[src_b];
    assign dbg_val = (dbg_sel == RNONE) ? 64'd0 : r_regs[dbg_sel];

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode and write-back: derives srcA/srcB/dstE/dstM from icode and feeds the register file.
// Decode and reads are combinational; write-back commits 1 edge later; no backpressure.
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        Cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    input  logic [3:0]  dbg_sel,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] dbg_val
);

    logic [3:0] w_src_a;
    logic [3:0] w_src_b;
    logic [3:0] w_dst_e;
    logic [3:0] w_dst_m;

    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;

        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: w_src_a = rA;
            IRET, IPOPQ:                    w_src_a = RRSP;
            default:                        w_src_a = RNONE;
        endcase

        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         w_src_b = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     w_src_b = RRSP;
            default:                        w_src_b = RNONE;
        endcase

        // cmovXX squashes its destination when the condition fails; rrmovq arrives with Cnd=1.
        case (icode)
            IRRMOVQ:                        w_dst_e = Cnd ? rB : RNONE;
            IIRMOVQ, IOPQ:                  w_dst_e = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     w_dst_e = RRSP;
            default:                        w_dst_e = RNONE;
        endcase

        case (icode)
            IMRMOVQ, IPOPQ:                 w_dst_m = rA;
            default:                        w_dst_m = RNONE;
        endcase
    end

    assign srcA = w_src_a;
    assign srcB = w_src_b;
    assign dstE = w_dst_e;
    assign dstM = w_dst_m;

    y86_regfile #(
        .STACK_INIT (STACK_INIT)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .dst_e   (w_dst_e),
        .val_e   (valE),
        .dst_m   (w_dst_m),
        .val_m   (valM),
        .src_a   (w_src_a),
        .src_b   (w_src_b),
        .dbg_sel (dbg_sel),
        .val_a   (valA),
        .val_b   (valB),
        .dbg_val (dbg_val)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed-vector bench for decode_writeback with hand-computed expectations.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB, dbg_sel;
    logic        Cnd, wb_en;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, dbg_val;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    decode_writeback dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .icode   (icode),
        .rA      (rA),
        .rB      (rB),
        .Cnd     (Cnd),
        .valE    (valE),
        .valM    (valM),
        .wb_en   (wb_en),
        .dbg_sel (dbg_sel),
        .srcA    (srcA),
        .srcB    (srcB),
        .dstE    (dstE),
        .dstM    (dstM),
        .valA    (valA),
        .valB    (valB),
        .dbg_val (dbg_val)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [63:0] exp);
        dbg_sel = idx;
        #1;
        chk(tag, dbg_val, exp);
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [63:0] e, input logic [63:0] m,
                         input logic en);
        icode = ic; rA = a; rB = b; Cnd = c; valE = e; valM = m; wb_en = en;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; dbg_sel = 4'h0;
        drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);

        // 1. reset
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++)
            chk($sformatf("rst_r%0d", i), (i == 4) ? 64'h1000 : 64'd0,
                (i == 4) ? 64'h1000 : 64'd0) ;
        n_vec  = 0;
        for (int i = 0; i < 15; i++)
            chk_reg($sformatf("rst_r%0d", i), 4'(i), (i == 4) ? 64'h1000 : 64'd0);
        chk_reg("dbg_none", 4'hF, 64'd0);
        drive(4'h9, 4'h1, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("ret_srcA", {60'd0, srcA}, 64'h4);
        chk("ret_srcB", {60'd0, srcB}, 64'h4);
        chk("ret_dstM", {60'd0, dstM}, 64'hF);
        chk("ret_valA", valA, 64'h1000);
        chk("ret_valB", valB, 64'h1000);

        // 2. irmovq then OPq reading it back
        drive(4'h3, 4'hF, 4'h2, 1'b0, 64'hDEAD_BEEF, 64'd0, 1'b1);
        chk("irm_dstE", {60'd0, dstE}, 64'h2);
        chk("irm_srcA", {60'd0, srcA}, 64'hF);
        chk_reg("irm_pre_r2", 4'h2, 64'd0);
        tick();
        chk_reg("irm_r2", 4'h2, 64'hDEAD_BEEF);
        drive(4'h6, 4'h2, 4'h2, 1'b0, 64'd0, 64'd0, 1'b0);
        chk("opq_valA", valA, 64'hDEAD_BEEF);
        chk("opq_valB", valB, 64'hDEAD_BEEF);
        chk("opq_dstE", {60'd0, dstE}, 64'h2);

        // 3. cmovXX not taken, then taken
        drive(4'h2, 4'h1, 4'h3, 1'b0, 64'd5, 64'd0, 1'b1);
        chk("cmov_nt_dstE", {60'd0, dstE}, 64'hF);
        chk("cmov_srcA", {60'd0, srcA}, 64'h1);
        tick();
        chk_reg("cmov_nt_r3", 4'h3, 64'd0);
        drive(4'h2, 4'h1, 4'h3, 1'b1, 64'd5, 64'd0, 1'b1);
        chk("cmov_t_dstE", {60'd0, dstE}, 64'h3);
        tick();
        chk_reg("cmov_t_r3", 4'h3, 64'd5);

        // 4. popq %rsp: M port wins
        drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h1008, 64'h77, 1'b1);
        chk("pop_dstE", {60'd0, dstE}, 64'h4);
        chk("pop_dstM", {60'd0, dstM}, 64'h4);
        chk("pop_valA", valA, 64'h1000);
        tick();
        chk_reg("pop_r4", 4'h4, 64'h77);

        // pushq and call update %rsp through E
        drive(4'hA, 4'h3, 4'hF, 1'b0, 64'h70, 64'd0, 1'b1);
        chk("push_srcA", {60'd0, srcA}, 64'h3);
        chk("push_valA", valA, 64'd5);
        chk("push_valB", valB, 64'h77);
        tick();
        chk_reg("push_r4", 4'h4, 64'h70);
        drive(4'h8, 4'hF, 4'hF, 1'b0, 64'h68, 64'd0, 1'b1);
        chk("call_srcA", {60'd0, srcA}, 64'hF);
        tick();
        chk_reg("call_r4", 4'h4, 64'h68);

        // 5. gated by wb_en; mrmovq write; reset discards pending write
        drive(4'h3, 4'hF, 4'h5, 1'b0, 64'd9, 64'd0, 1'b0);
        tick();
        chk_reg("gate_r5", 4'h5, 64'd0);
        drive(4'h5, 4'h6, 4'h2, 1'b0, 64'h10, 64'h1234, 1'b1);
        chk("mrm_dstM", {60'd0, dstM}, 64'h6);
        chk("mrm_dstE", {60'd0, dstE}, 64'hF);
        chk("mrm_srcB", {60'd0, srcB}, 64'h2);
        tick();
        chk_reg("mrm_r6", 4'h6, 64'h1234);
        drive(4'h5, 4'h6, 4'h2, 1'b0, 64'h10, 64'h5555, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reg("rstmid_r6", 4'h6, 64'd0);
        chk_reg("rstmid_r4", 4'h4, 64'h1000);
        chk_reg("rstmid_r2", 4'h2, 64'd0);
        chk_reg("rstmid_r3", 4'h3, 64'd0);

        // 6. nop and undefined icodes never write
        drive(4'h3, 4'hF, 4'h7, 1'b0, 64'hABC, 64'd0, 1'b1);
        tick();
        chk_reg("pre_nop_r7", 4'h7, 64'hABC);
        drive(4'h1, 4'h7, 4'h7, 1'b1, 64'h1111, 64'h2222, 1'b1);
        chk("nop_srcA", {60'd0, srcA}, 64'hF);
        chk("nop_srcB", {60'd0, srcB}, 64'hF);
        chk("nop_dstE", {60'd0, dstE}, 64'hF);
        chk("nop_dstM", {60'd0, dstM}, 64'hF);
        chk("nop_valA", valA, 64'd0);
        chk("nop_valB", valB, 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk_reg("nop_r7", 4'h7, 64'hABC);
        chk_reg("nop_r4", 4'h4, 64'h1000);
        chk_reg("nop_r0", 4'h0, 64'd0);
        drive(4'hC, 4'h1, 4'h1, 1'b1, 64'h3333, 64'h4444, 1'b1);
        chk("undef_dstE", {60'd0, dstE}, 64'hF);
        chk("undef_dstM", {60'd0, dstM}, 64'hF);
        tick();
        chk_reg("undef_r1", 4'h1, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
